systolic_array_4x4: RTL and testbench

//  4x4 weight-stationary systolic MAC array of 16 PEs, each holding regs a, b and ps.
//  - B weights shift down the columns.
//  - A operands shift right along the rows.
//  - Partial sums shift down and accumulate a*b at every row.

---
 rtl/systolic_array_4x4_if.sv | 24 ++
 rtl/systolic_array_4x4.sv | 87 ++++++++
 tb/tb_systolic_array_4x4.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_4x4_if.sv
// rtl/systolic_array_4x4_if.sv - shift strobes and flattened operand buses of the 4x4 systolic array
// master drives strobes and edge operands; slave is the array.
interface systolic_array_4x4_if;
  logic        data_clear;
  logic        en_b_shift_bottom;
  logic        en_shift_right;
  logic        en_shift_bottom;
  logic [63:0] a_left_in_flat;
  logic [63:0] b_top_in_flat;
  logic [63:0] ps_top_in_flat;
  logic [63:0] ps_bottom_out_flat;

  modport master (
    output data_clear, en_b_shift_bottom, en_shift_right, en_shift_bottom,
    output a_left_in_flat, b_top_in_flat, ps_top_in_flat,
    input  ps_bottom_out_flat
  );

  modport slave (
    input  data_clear, en_b_shift_bottom, en_shift_right, en_shift_bottom,
    input  a_left_in_flat, b_top_in_flat, ps_top_in_flat,
    output ps_bottom_out_flat
  );
endinterface

// File: rtl/systolic_array_4x4.sv
// rtl/systolic_array_4x4.sv - 4x4 weight-stationary MAC array, 16-bit signed, wrap by default
// Define SA_SATURATE_EN to clamp every PE result to [-32768, 32767] instead of wrapping.
module systolic_array_4x4 (
  input  logic                 Clock,
  input  logic                 rst_n,
  systolic_array_4x4_if.slave  sa
);

  logic [3:0][3:0][15:0] a_q, a_d;
  logic [3:0][3:0][15:0] b_q, b_d;
  logic [3:0][3:0][15:0] ps_q, ps_d;

  function automatic logic [15:0] mac(input logic [15:0] ps_in,
                                      input logic [15:0] av,
                                      input logic [15:0] bv);
`ifdef SA_SATURATE_EN
    logic signed [31:0] sa_ext;
    logic signed [31:0] sb_ext;
    logic signed [31:0] prod;
    logic signed [33:0] sum;
    sa_ext = {{16{av[15]}}, av};
    sb_ext = {{16{bv[15]}}, bv};
    prod   = sa_ext * sb_ext;
    sum    = $signed({{18{ps_in[15]}}, ps_in}) + $signed({{2{prod[31]}}, prod});
    if (sum > 34'sd32767)
      mac = 16'h7FFF;
    else if (sum < -34'sd32768)
      mac = 16'h8000;
    else
      mac = sum[15:0];
`else
    // Low 16 bits of a two's complement product do not depend on signedness.
    logic [15:0] prod;
    prod = av * bv;
    mac  = ps_in + prod;
`endif
  endfunction

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    ps_d = ps_q;
    if (sa.data_clear) begin
      a_d  = '0;
      b_d  = '0;
      ps_d = '0;
    end else begin
      if (sa.en_shift_right) begin
        for (int i = 0; i < 4; i++) begin
          a_d[i][0] = sa.a_left_in_flat[i*16 +: 16];
          for (int j = 1; j < 4; j++)
            a_d[i][j] = a_q[i][j-1];
        end
      end
      if (sa.en_b_shift_bottom) begin
        for (int j = 0; j < 4; j++) begin
          b_d[0][j] = sa.b_top_in_flat[j*16 +: 16];
          for (int i = 1; i < 4; i++)
            b_d[i][j] = b_q[i-1][j];
        end
      end
      // MAC reads pre-edge a/b, so concurrent A/B shifts never feed this edge's products.
      if (sa.en_shift_bottom) begin
        for (int j = 0; j < 4; j++) begin
          ps_d[0][j] = mac(sa.ps_top_in_flat[j*16 +: 16], a_q[0][j], b_q[0][j]);
          for (int i = 1; i < 4; i++)
            ps_d[i][j] = mac(ps_q[i-1][j], a_q[i][j], b_q[i][j]);
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      ps_q <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      ps_q <= ps_d;
    end
  end

  assign sa.ps_bottom_out_flat = ps_q[3];

endmodule

// File: tb/tb_systolic_array_4x4.sv
// tb/tb_systolic_array_4x4.sv - directed self-checking bench for systolic_array_4x4
module tb_systolic_array_4x4;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  systolic_array_4x4_if sa_if ();

  systolic_array_4x4 dut (
    .Clock (clk),
    .rst_n (rst),
    .sa    (sa_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] vec(input logic [15:0] c0, input logic [15:0] c1,
                                      input logic [15:0] c2, input logic [15:0] c3);
    vec = {c3, c2, c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_b(input logic [63:0] v);
    sa_if.b_top_in_flat = v;
    sa_if.en_b_shift_bottom = 1'b1;
    tick();
    sa_if.en_b_shift_bottom = 1'b0;
  endtask

  task automatic push_a(input logic [63:0] v);
    sa_if.a_left_in_flat = v;
    sa_if.en_shift_right = 1'b1;
    tick();
    sa_if.en_shift_right = 1'b0;
  endtask

  task automatic push_ps(input logic [63:0] v);
    sa_if.ps_top_in_flat = v;
    sa_if.en_shift_bottom = 1'b1;
    tick();
    sa_if.en_shift_bottom = 1'b0;
  endtask

  task automatic clear();
    sa_if.data_clear = 1'b1;
    tick();
    sa_if.data_clear = 1'b0;
  endtask

  task automatic load_uniform(input logic [15:0] av, input logic [15:0] bv);
    for (int k = 0; k < 4; k++) push_b({4{bv}});
    for (int k = 0; k < 4; k++) push_a({4{av}});
  endtask

  task automatic test_reset();
    logic [15:0] exp [4];
    exp = '{16'h0, 16'h0, 16'h0, 16'h0};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (sa_if.ps_bottom_out_flat[j*16 +: 16] !== exp[j]) begin
        n_err++;
        $display("FAIL reset col%0d got %h want %h", j, sa_if.ps_bottom_out_flat[j*16 +: 16], exp[j]);
      end
    end
    repeat (3) tick();
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (sa_if.ps_bottom_out_flat[j*16 +: 16] !== exp[j]) begin
        n_err++;
        $display("FAIL reset_hold col%0d got %h want %h", j, sa_if.ps_bottom_out_flat[j*16 +: 16], exp[j]);
      end
    end
  endtask

  task automatic test_basic_mac();
    clear();
    load_uniform(16'd2, 16'd1);
    for (int k = 0; k < 4; k++) push_ps(64'h0);
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (sa_if.ps_bottom_out_flat[j*16 +: 16] !== 16'h0008) begin
        n_err++;
        $display("FAIL basic_mac col%0d got %h want 0008", j, sa_if.ps_bottom_out_flat[j*16 +: 16]);
      end
    end
    repeat (2) tick();
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (sa_if.ps_bottom_out_flat[j*16 +: 16] !== 16'h0008) begin
        n_err++;
        $display("FAIL basic_hold col%0d got %h want 0008", j, sa_if.ps_bottom_out_flat[j*16 +: 16]);
      end
    end
  endtask

  task automatic test_clear_latency();
    clear();
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (sa_if.ps_bottom_out_flat[j*16 +: 16] !== 16'h0000) begin
        n_err++;
        $display("FAIL clear col%0d got %h want 0000", j, sa_if.ps_bottom_out_flat[j*16 +: 16]);
      end
    end
    push_ps({4{16'd5}});
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (sa_if.ps_bottom_out_flat[j*16 +: 16] !== 16'h0000) begin
        n_err++;
        $display("FAIL clear_shift1 col%0d got %h want 0000", j, sa_if.ps_bottom_out_flat[j*16 +: 16]);
      end
    end
    push_ps({4{16'd5}});
    push_ps({4{16'd5}});
    n_cmp++;
    if (sa_if.ps_bottom_out_flat !== 64'h0) begin
      n_err++;
      $display("FAIL latency_3 got %h want 0", sa_if.ps_bottom_out_flat);
    end
    push_ps({4{16'd5}});
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (sa_if.ps_bottom_out_flat[j*16 +: 16] !== 16'h0005) begin
        n_err++;
        $display("FAIL latency_4 col%0d got %h want 0005", j, sa_if.ps_bottom_out_flat[j*16 +: 16]);
      end
    end
  endtask

  task automatic test_signed();
    clear();
    load_uniform(16'hFFFF, 16'd3);
    for (int k = 0; k < 4; k++) push_ps(64'h0);
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (sa_if.ps_bottom_out_flat[j*16 +: 16] !== 16'hFFF4) begin
        n_err++;
        $display("FAIL signed col%0d got %h want fff4", j, sa_if.ps_bottom_out_flat[j*16 +: 16]);
      end
    end
  endtask

  task automatic test_column_weights();
    logic [15:0] exp [4];
    exp = '{16'd4, 16'd3, 16'd2, 16'd1};
    clear();
    push_b(vec(16'd1, 16'd0, 16'd0, 16'd0));
    push_b(vec(16'd0, 16'd1, 16'd0, 16'd0));
    push_b(vec(16'd0, 16'd0, 16'd1, 16'd0));
    push_b(vec(16'd0, 16'd0, 16'd0, 16'd1));
    for (int k = 0; k < 4; k++) push_a(vec(16'd1, 16'd2, 16'd3, 16'd4));
    for (int k = 0; k < 4; k++) push_ps(64'h0);
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (sa_if.ps_bottom_out_flat[j*16 +: 16] !== exp[j]) begin
        n_err++;
        $display("FAIL col_weights col%0d got %h want %h", j, sa_if.ps_bottom_out_flat[j*16 +: 16], exp[j]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (sa_if.ps_bottom_out_flat !== 64'h0) begin
      n_err++;
      $display("FAIL reset_midrun got %h want 0", sa_if.ps_bottom_out_flat);
    end
    for (int k = 0; k < 4; k++) push_ps(64'h0);
    n_cmp++;
    if (sa_if.ps_bottom_out_flat !== 64'h0) begin
      n_err++;
      $display("FAIL reset_discard got %h want 0", sa_if.ps_bottom_out_flat);
    end
  endtask

  task automatic test_simultaneous();
    clear();
    sa_if.a_left_in_flat = {4{16'd3}};
    sa_if.b_top_in_flat  = {4{16'd4}};
    sa_if.ps_top_in_flat = 64'h0;
    sa_if.en_shift_right = 1'b1;
    sa_if.en_b_shift_bottom = 1'b1;
    sa_if.en_shift_bottom = 1'b1;
    tick();
    sa_if.en_shift_right = 1'b0;
    sa_if.en_b_shift_bottom = 1'b0;
    sa_if.en_shift_bottom = 1'b0;
    for (int k = 0; k < 3; k++) push_ps(64'h0);
    n_cmp++;
    if (sa_if.ps_bottom_out_flat !== 64'h0) begin
      n_err++;
      $display("FAIL simul_old_ab got %h want 0", sa_if.ps_bottom_out_flat);
    end
    push_ps(64'h0);
    n_cmp++;
    if (sa_if.ps_bottom_out_flat !== vec(16'd12, 16'd0, 16'd0, 16'd0)) begin
      n_err++;
      $display("FAIL simul_pipe got %h want %h", sa_if.ps_bottom_out_flat, vec(16'd12, 16'd0, 16'd0, 16'd0));
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_ov;
`ifdef SA_SATURATE_EN
    exp_ov = 16'h7FFF;
`else
    exp_ov = 16'h8000;
`endif
    clear();
    for (int k = 0; k < 3; k++) push_b(64'h0);
    push_b({4{16'd2}});
    for (int k = 0; k < 4; k++) push_a(vec(16'h4000, 16'h0, 16'h0, 16'h0));
    for (int k = 0; k < 4; k++) push_ps(64'h0);
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (sa_if.ps_bottom_out_flat[j*16 +: 16] !== exp_ov) begin
        n_err++;
        $display("FAIL overflow col%0d got %h want %h", j, sa_if.ps_bottom_out_flat[j*16 +: 16], exp_ov);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    sa_if.data_clear = 1'b0;
    sa_if.en_b_shift_bottom = 1'b0;
    sa_if.en_shift_right = 1'b0;
    sa_if.en_shift_bottom = 1'b0;
    sa_if.a_left_in_flat = 64'h0;
    sa_if.b_top_in_flat = 64'h0;
    sa_if.ps_top_in_flat = 64'h0;
    #2;
    test_reset();
    test_basic_mac();
    test_clear_latency();
    test_signed();
    test_column_weights();
    test_reset_midrun();
    test_simultaneous();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
